// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared types and constants for the CPU memory port arbiter
// Contents: arb_state_t arbiter state enum, AW/DW default widths, requester codes.
package cpu_mem_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  // Requester encoding used wherever a grant owner has to be named.
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  // LOCK is only reachable when the SWP lock feature is compiled in.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    LOCK   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arb_wdog.sv
// rtl/mem_arb_wdog.sv - wait-state watchdog counter for the memory port arbiter
// Ports: clk, rst_n (async active-low), clr (restart count), en (count this edge),
//        timeout (high in the cycle whose edge would bring the count to TO_CYCLES).
// TO_CYCLES = 0 removes the counter and timeout never asserts.
module mem_arb_wdog #(
  parameter int TO_CYCLES = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  generate
    if (TO_CYCLES == 0) begin : g_off
      assign timeout = 1'b0;
    end else begin : g_on
      localparam int CW = (TO_CYCLES < 2) ? 1 : $clog2(TO_CYCLES + 1);
      logic [CW-1:0] cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (clr) begin
          cnt <= '0;
        end else if (en) begin
          cnt <= cnt + CW'(1);
        end
      end

      // Flag one count early so the caller can act on the edge where it reaches TO_CYCLES.
      assign timeout = en && (cnt == CW'(TO_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch (I) and data (D) requesters
// Ports: clk, rst_n (async active-low); i_req/i_addr -> i_ack/i_rdata;
//        d_req/d_we/d_addr/d_wdata[/d_lock] -> d_ack/d_rdata; bus_err on timeout;
//        mem_en/mem_we/mem_addr/mem_wdata -> memory, mem_rdata/mem_ready <- memory.
// Macro ARB_SWP_LOCK_EN adds d_lock and the LOCK state for back-to-back SWP accesses.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = 4,
  parameter int TO_CYCLES  = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
`ifdef ARB_SWP_LOCK_EN
  input  logic          d_lock,
`endif
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          bus_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  arb_state_t state, state_nxt;
  logic       grant_i, grant_d;
  logic       i_vld, d_vld, busy, tmo;
  logic [3:0] starve_cnt, starve_nxt;

  logic          i_ack_nxt, d_ack_nxt, bus_err_nxt;
  logic [DW-1:0] i_rdata_nxt, d_rdata_nxt;
  logic          mem_en_nxt, mem_we_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic [DW-1:0] mem_wdata_nxt;

`ifdef ARB_SWP_LOCK_EN
  logic lock_q;  // the D access in flight was granted with d_lock set
`endif

  // A requester is ignored in its own ack cycle; its req is still the old one.
  assign i_vld = i_req && !i_ack;
  assign d_vld = d_req && !d_ack;
  assign busy  = (state == BUSY_I) || (state == BUSY_D);

  mem_arb_wdog #(.TO_CYCLES(TO_CYCLES)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (grant_i || grant_d),
    .en      (busy && !mem_ready),
    .timeout (tmo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin : next_state_comb
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (d_vld && !(i_vld && starve_cnt == 4'(STARVE_MAX))) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end else if (i_vld) begin
          grant_i   = 1'b1;
          state_nxt = BUSY_I;
        end
      end
      BUSY_I: if (mem_ready || tmo) state_nxt = IDLE;
      BUSY_D: begin
`ifdef ARB_SWP_LOCK_EN
        // A timeout never lands in LOCK, so it also drops the lock.
        if (mem_ready)  state_nxt = lock_q ? LOCK : IDLE;
        else if (tmo)   state_nxt = IDLE;
`else
        if (mem_ready || tmo) state_nxt = IDLE;
`endif
      end
`ifdef ARB_SWP_LOCK_EN
      LOCK: begin
        if (d_vld) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end else if (!d_req && !d_lock) begin
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin : output_comb
    i_ack_nxt     = 1'b0;
    d_ack_nxt     = 1'b0;
    bus_err_nxt   = 1'b0;
    i_rdata_nxt   = i_rdata;
    d_rdata_nxt   = d_rdata;
    mem_en_nxt    = mem_en;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    starve_nxt    = starve_cnt;

    if (grant_i || grant_d) begin
      mem_en_nxt    = 1'b1;
      mem_we_nxt    = grant_d && d_we;
      mem_addr_nxt  = grant_d ? d_addr : i_addr;
      mem_wdata_nxt = grant_d ? d_wdata : '0;
    end

    // mem_ready takes priority over a timeout landing on the same edge.
    if (busy && (mem_ready || tmo)) begin
      mem_en_nxt  = 1'b0;
      bus_err_nxt = !mem_ready;
      if (state == BUSY_I) begin
        i_ack_nxt   = 1'b1;
        i_rdata_nxt = mem_ready ? mem_rdata : '0;
      end else begin
        d_ack_nxt   = 1'b1;
        d_rdata_nxt = mem_ready ? mem_rdata : '0;
      end
    end

    // Starvation tracking only moves in IDLE; it is frozen while busy or locked.
    if (state == IDLE) begin
      if (!i_req || grant_i)
        starve_nxt = '0;
      else if (grant_d && i_vld && starve_cnt != 4'(STARVE_MAX))
        starve_nxt = starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      bus_err    <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      starve_cnt <= '0;
    end else begin
      i_ack      <= i_ack_nxt;
      d_ack      <= d_ack_nxt;
      bus_err    <= bus_err_nxt;
      i_rdata    <= i_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
      mem_en     <= mem_en_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      starve_cnt <= starve_nxt;
    end
  end

`ifdef ARB_SWP_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       lock_q <= 1'b0;
    else if (grant_d) lock_q <= d_lock;
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import cpu_mem_pkg::*;

  localparam int SM = 4;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we, d_lock, mem_ready;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_ack, d_ack, bus_err, mem_en, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(SM), .TO_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
`ifdef ARB_SWP_LOCK_EN
    .d_lock(d_lock),
`endif
    .d_ack(d_ack), .d_rdata(d_rdata), .bus_err(bus_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit actual=running required=finished");
    $fatal(1, "time limit");
  end

  // ---------------- directed single-transaction table ----------------
  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;    // cycles after mem_en rises before mem_ready; >=40 means never
    logic [31:0] rdata;
    int          exp_cyc;  // cycle of the ack, request sampled at the end of cycle 0
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v, input int idx);
    int          en_start = -1;
    int          ack_c = -1;
    logic        err = 1'b0, en_at_ack = 1'b1, we_s = 1'b0;
    logic [31:0] rd = '0, addr_s = '0, wd_s = '0;
    @(negedge clk);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    mem_rdata = v.rdata;
    for (int c = 1; c <= 40 && ack_c < 0; c++) begin
      @(posedge clk); #1;
      if (v.is_d ? d_ack : i_ack) begin
        ack_c = c; err = bus_err; en_at_ack = mem_en;
        rd = v.is_d ? d_rdata : i_rdata;
        i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
      end else if (mem_en) begin
        if (en_start < 0) begin
          en_start = c; we_s = mem_we; addr_s = mem_addr; wd_s = mem_wdata;
        end
        mem_ready = (c - en_start == v.delay);
      end
    end
    i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    chk($sformatf("vec%0d_ack_cycle", idx), ack_c, v.exp_cyc);
    chk($sformatf("vec%0d_bus_err", idx), err, v.exp_err);
    chk($sformatf("vec%0d_rdata", idx), rd, v.exp_rd);
    chk($sformatf("vec%0d_mem_we", idx), we_s, v.is_d && v.we);
    chk($sformatf("vec%0d_mem_addr", idx), addr_s, v.addr);
    chk($sformatf("vec%0d_mem_wdata", idx), wd_s, v.is_d ? v.wdata : 32'h0);
    chk($sformatf("vec%0d_mem_en_at_ack", idx), en_at_ack, 1'b0);
    repeat (2) @(posedge clk);
  endtask

  // ---------------- behavioural reference for the random phase ----------------
  int          m_own;    // 0 nobody, 1 fetch, 2 data
  int          m_wait;
  int          m_starve;
  logic        e_iack, e_dack, e_err, e_en, e_we;
  logic [31:0] e_ird, e_drd, e_addr, e_wd;

  task automatic model_reset();
    m_own = 0; m_wait = 0; m_starve = 0;
    e_iack = 0; e_dack = 0; e_err = 0; e_en = 0; e_we = 0;
    e_ird = 0; e_drd = 0; e_addr = 0; e_wd = 0;
  endtask

  // Advances the reference by one clock edge using the inputs currently driven.
  task automatic model_step();
    logic iv, dv, n_iack = 0, n_dack = 0, n_err = 0;
    int   g = 0;
    if (m_own == 0) begin
      iv = i_req && !e_iack;
      dv = d_req && !e_dack;
      if (dv && !(iv && m_starve == SM)) g = 2;
      else if (iv) g = 1;
      if (!i_req || g == 1) m_starve = 0;
      else if (g == 2 && iv && m_starve < SM) m_starve++;
      if (g != 0) begin
        m_own = g; m_wait = 0; e_en = 1;
        e_addr = (g == 2) ? d_addr : i_addr;
        e_we   = (g == 2) && d_we;
        e_wd   = (g == 2) ? d_wdata : 32'h0;
      end
    end else if (mem_ready || (TO > 0 && m_wait + 1 == TO)) begin
      if (m_own == 1) begin n_iack = 1; e_ird = mem_ready ? mem_rdata : 32'h0; end
      else            begin n_dack = 1; e_drd = mem_ready ? mem_rdata : 32'h0; end
      n_err = !mem_ready; e_en = 0; m_own = 0;
    end else begin
      m_wait++;
    end
    e_iack = n_iack; e_dack = n_dack; e_err = n_err;
  endtask

  initial begin
    logic  prev_en;
    int    dcount, first_i, acks, ens;
    logic  grants[$];
    int    gcyc[$];
    int    dack_n, dack2_c;

    rst_n = 1'b0;
    i_req = 0; d_req = 0; d_we = 0; d_lock = 0; mem_ready = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;

    vecs[0] = '{1'b0, 1'b0, 32'h100, 32'h0,        1,  32'hE3A00001, 3,  1'b0, 32'hE3A00001};
    vecs[1] = '{1'b1, 1'b0, 32'h104, 32'h0,        0,  32'h12345678, 2,  1'b0, 32'h12345678};
    vecs[2] = '{1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 2,  32'hAAAA5555, 4,  1'b0, 32'hAAAA5555};
    vecs[3] = '{1'b1, 1'b0, 32'h208, 32'h0,        99, 32'hBAD0BAD0, 16, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 32'h10C, 32'h0,        14, 32'h0F0F0F0F, 16, 1'b0, 32'h0F0F0F0F};
    vecs[5] = '{1'b0, 1'b0, 32'h110, 32'h0,        13, 32'h11223344, 15, 1'b0, 32'h11223344};
    vecs[6] = '{1'b0, 1'b0, 32'h114, 32'h0,        99, 32'h55555555, 16, 1'b1, 32'h0};

    #17;
    chk("reset_mem_en", mem_en, 1'b0);
    chk("reset_acks", {i_ack, d_ack, bus_err}, 3'b000);
    chk("reset_mem_bus", {mem_we, mem_addr, mem_wdata}, 65'h0);
    chk("reset_rdata", {i_rdata, d_rdata}, 64'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[k]) run_vec(vecs[k], k);

    // Simultaneous requests: D first, I right after D's ack.
    @(negedge clk);
    i_req = 1; i_addr = 32'h300;
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    chk("both_first_grant", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 32'h200, 32'hDEADBEEF});
    mem_ready = 1; mem_rdata = 32'h0;
    @(posedge clk); #1;
    chk("both_d_ack", {d_ack, i_ack, mem_en}, 3'b100);
    d_req = 0; mem_ready = 0;
    @(posedge clk); #1;
    chk("both_i_grant", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 32'h300});
    mem_ready = 1; mem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    chk("both_i_ack", {i_ack, i_rdata}, {1'b1, 32'hCAFEF00D});
    i_req = 0; mem_ready = 0;
    repeat (2) @(posedge clk);

    // I held while D keeps requesting: I must not wait behind more than SM D grants.
    @(negedge clk);
    i_req = 1; i_addr = 32'h400; d_req = 1; d_we = 0; d_addr = 32'h500;
    mem_ready = 1; mem_rdata = 32'h77;
    dcount = 0; first_i = -1; prev_en = 0;
    for (int c = 0; c < 60 && first_i < 0; c++) begin
      @(posedge clk); #1;
      if (mem_en && !prev_en) begin
        if (mem_addr == 32'h500) dcount++;
        else if (mem_addr == 32'h400) first_i = c;
      end
      prev_en = mem_en;
    end
    d_req = 0;
    chk("starve_i_granted", first_i >= 0, 1'b1);
    chk("starve_d_grants_in_range", (dcount >= 1) && (dcount <= SM), 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (i_ack) i_req = 0;
    end
    i_req = 0; mem_ready = 0;
    repeat (2) @(posedge clk);

`ifdef ARB_SWP_LOCK_EN
    // SWP: locked read then unlocked write, no fetch in between.
    @(negedge clk);
    i_req = 1; i_addr = 32'h600;
    d_req = 1; d_lock = 1; d_we = 0; d_addr = 32'h700;
    mem_ready = 1; mem_rdata = 32'h99;
    dack_n = 0; dack2_c = -1; prev_en = 0;
    for (int c = 0; c < 60 && i_req; c++) begin
      @(posedge clk); #1;
      if (mem_en && !prev_en) begin
        grants.push_back(mem_addr == 32'h600 ? REQ_I : REQ_D);
        gcyc.push_back(c);
      end
      prev_en = mem_en;
      if (d_ack) begin
        dack_n++;
        if (dack_n == 1) begin d_lock = 0; d_we = 1; d_wdata = 32'h5A5A5A5A; end
        else begin d_req = 0; dack2_c = c; end
      end
      if (i_ack) i_req = 0;
    end
    i_req = 0; d_req = 0; mem_ready = 0;
    chk("lock_grant_count", grants.size(), 3);
    if (grants.size() == 3) begin
      chk("lock_grant_order", {grants[0], grants[1], grants[2]}, {REQ_D, REQ_D, REQ_I});
      chk("lock_i_after_d_ack", gcyc[2], dack2_c + 1);
    end
    repeat (2) @(posedge clk);
`endif

    // Reset while a D access is waiting on memory.
    @(negedge clk);
    d_req = 1; d_we = 0; d_addr = 32'h800; mem_ready = 0;
    repeat (3) @(posedge clk);
    #1 chk("rst_pre_mem_en", mem_en, 1'b1);
    @(negedge clk) rst_n = 0;
    #1;
    chk("rst_mid_busy_outputs", {mem_en, i_ack, d_ack}, 3'b000);
    d_req = 0;
    @(negedge clk) rst_n = 1;
    mem_ready = 1;
    acks = 0; ens = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (i_ack || d_ack || bus_err) acks++;
      if (mem_en) ens++;
    end
    chk("rst_no_ack_after", acks, 0);
    chk("rst_stays_idle", ens, 0);
    mem_ready = 0;

    // Randomized traffic against the reference model.
    @(negedge clk) rst_n = 0;
    @(negedge clk) rst_n = 1;
    model_reset();
    for (int cyc = 0; cyc < 3000 && failures < 20; cyc++) begin
      model_step();
      @(posedge clk); #1;
      chk($sformatf("rand_cycle%0d", cyc),
          {i_ack, d_ack, bus_err, mem_en, mem_we, mem_addr, mem_wdata, i_rdata, d_rdata},
          {e_iack, e_dack, e_err, e_en, e_we, e_addr, e_wd, e_ird, e_drd});
      if (i_ack) i_req = 0;
      if (d_ack) d_req = 0;
      if (!i_req && $urandom_range(2) == 0) begin
        i_req = 1; i_addr = $urandom;
      end
      if (!d_req && $urandom_range(2) == 0) begin
        d_req = 1; d_we = $urandom_range(1); d_addr = $urandom; d_wdata = $urandom;
      end
      case ((cyc / 250) % 3)
        0:       mem_ready = ($urandom_range(1) == 0);
        1:       mem_ready = ($urandom_range(7) == 0);
        default: mem_ready = ($urandom_range(39) == 0);
      endcase
      mem_rdata = $urandom;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
